// File: rtl/motion_sensor_burst_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motion_sensor_burst_interface: SPI motion-sensor burst reader driven by     |
// | interrupt or power-mode poll timer. Revision 1.0                             |
// +----------------------------------------------------------------------------+
module motion_sensor_burst_interface #(
    parameter int         NUM_BYTES   = 2,
    parameter int         CNT_W       = 8,
    parameter int         PERIOD_W    = 18,
    parameter int         POLL_NORMAL = 50000,
    parameter int         POLL_LOW    = 100000,
    parameter int         POLL_SLEEP  = 200000,
    parameter int         SPI_TIMEOUT = 1024,
    parameter logic [7:0] READ_CMD    = 8'hA0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [1:0]             power_mode,
    input  logic                   motion_int,
    output logic [8*NUM_BYTES-1:0] sensor_data,
    output logic [CNT_W-1:0]       event_count,
    output logic                   data_valid,
    output logic                   busy,
    output logic                   sensor_error,
    output logic                   start_spi,
    output logic [7:0]             spi_tx_data,
    input  logic [7:0]             spi_rx_data,
    input  logic                   spi_done
);

    localparam int                  DATA_W    = 8 * NUM_BYTES;
    localparam int                  IDX_W     = 3;
    localparam int                  WAIT_W    = $clog2(SPI_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_BYTES);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(SPI_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   sensor_data_q, sensor_data_d;
    logic [CNT_W-1:0]    event_count_q, event_count_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [1:0]          mode_q;
    logic                dv_q, dv_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic [7:0]          tx_q, tx_d;

    logic                motion_edge;
    logic                timer_expired;
    logic                launch;
    logic                capture;
    logic [PERIOD_W-1:0] period;
    logic [IDX_W-1:0]    byte_pos;

    assign motion_edge   = sync2_q & ~prev_q;
    assign timer_expired = (timer_q == '0) && (power_mode != 2'b11);
    // First received data byte lands in the most significant slot.
    assign byte_pos      = LAST_IDX - idx_q;

    always_comb begin
        case (power_mode)
            2'b01:   period = PERIOD_W'(POLL_LOW);
            2'b10:   period = PERIOD_W'(POLL_SLEEP);
            default: period = PERIOD_W'(POLL_NORMAL);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        data_d        = data_q;
        sensor_data_d = sensor_data_q;
        event_count_d = event_count_q;
        cnt_d         = cnt_q;
        pending_d     = pending_q;
        timer_d       = timer_q;
        dv_d          = 1'b0;
        err_d         = err_q;
        start_d       = 1'b0;
        tx_d          = tx_q;
        launch        = 1'b0;
        capture       = 1'b0;

        if (motion_edge && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!enable) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            idx_d     = '0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (motion_edge || pending_q || timer_expired) begin
                        state_d = S_START;
                        idx_d   = '0;
                        launch  = 1'b1;
                    end else if (power_mode != 2'b11) begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_START: begin
                    start_d = 1'b1;
                    tx_d    = (idx_q == '0) ? READ_CMD : 8'h00;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        if (idx_q != '0) begin
                            data_d[{byte_pos, 3'b000} +: 8] = spi_rx_data;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            capture = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_START;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (pending_q) begin
                        state_d = S_START;
                        idx_d   = '0;
                        launch  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ERROR: begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (motion_edge && (state_q != S_IDLE)) begin
                pending_d = 1'b1;
            end
            if (launch) begin
                pending_d = 1'b0;
            end
        end

        if (capture) begin
            sensor_data_d = data_d;
            event_count_d = cnt_q;
            cnt_d         = CNT_W'(motion_edge);
            dv_d          = 1'b1;
            err_d         = 1'b0;
        end

        if (launch || (mode_q != power_mode) || (state_q == S_ERROR)) begin
            timer_d = period;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= motion_int;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wait_q        <= '0;
            data_q        <= '0;
            sensor_data_q <= '0;
            event_count_q <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            timer_q       <= PERIOD_W'(POLL_NORMAL);
            mode_q        <= 2'b00;
            dv_q          <= 1'b0;
            err_q         <= 1'b0;
            start_q       <= 1'b0;
            tx_q          <= 8'h00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wait_q        <= wait_d;
            data_q        <= data_d;
            sensor_data_q <= sensor_data_d;
            event_count_q <= event_count_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            timer_q       <= timer_d;
            mode_q        <= power_mode;
            dv_q          <= dv_d;
            err_q         <= err_d;
            start_q       <= start_d;
            tx_q          <= tx_d;
        end
    end

    assign sensor_data  = sensor_data_q;
    assign event_count  = event_count_q;
    assign data_valid   = dv_q;
    assign busy         = (state_q != S_IDLE);
    assign sensor_error = err_q;
    assign start_spi    = start_q;
    assign spi_tx_data  = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_motion_sensor_burst_interface.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench: expected tx bytes and captures are queued by the stimulus,
// a negedge monitor pops and compares whenever start_spi or data_valid fires.
module tb_motion_sensor_burst_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  power_mode = 2'b00;
    logic        motion_int = 1'b0;
    logic [15:0] sensor_data;
    logic [1:0]  event_count;
    logic        data_valid;
    logic        busy;
    logic        sensor_error;
    logic        start_spi;
    logic [7:0]  spi_tx_data;
    logic [7:0]  spi_rx_data = 8'h00;
    logic        spi_done = 1'b0;

    motion_sensor_burst_interface #(
        .NUM_BYTES   (2),
        .CNT_W       (2),
        .PERIOD_W    (18),
        .POLL_NORMAL (20),
        .POLL_LOW    (40),
        .POLL_SLEEP  (80),
        .SPI_TIMEOUT (8),
        .READ_CMD    (8'hA0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .power_mode   (power_mode),
        .motion_int   (motion_int),
        .sensor_data  (sensor_data),
        .event_count  (event_count),
        .data_valid   (data_valid),
        .busy         (busy),
        .sensor_error (sensor_error),
        .start_spi    (start_spi),
        .spi_tx_data  (spi_tx_data),
        .spi_rx_data  (spi_rx_data),
        .spi_done     (spi_done)
    );

    always #5 clk = ~clk;

    int          n_vec   = 0;
    int          n_fail  = 0;
    int          n_start = 0;
    logic [7:0]  exp_tx[$];
    logic [17:0] exp_cap[$];   // {sensor_data, event_count}
    logic [7:0]  rx_q[$];
    bit          resp_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (start_spi === 1'b1) begin
                n_start++;
                if (exp_tx.size() == 0) chk("unexpected start_spi", 32'(start_spi), 0);
                else chk("spi_tx_data", 32'(spi_tx_data), 32'(exp_tx.pop_front()));
            end
            if (data_valid === 1'b1) begin
                if (exp_cap.size() == 0) chk("unexpected data_valid", 32'(data_valid), 0);
                else begin
                    e = exp_cap.pop_front();
                    chk("sensor_data", 32'(sensor_data), 32'(e[17:2]));
                    chk("event_count", 32'(event_count), 32'(e[1:0]));
                end
            end
        end
    end

    // SPI master model: spi_done sampled three edges after each start_spi edge
    initial begin
        forever begin
            @(negedge clk);
            if (start_spi === 1'b1 && resp_en) begin
                repeat (2) @(negedge clk);
                spi_rx_data = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                spi_done    = 1'b1;
                @(negedge clk);
                spi_done    = 1'b0;
            end
        end
    end

    task automatic burst(input logic [7:0] b1, input logic [7:0] b2, input logic [1:0] cnt);
        exp_tx.push_back(8'hA0); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        rx_q.push_back(8'hAA);   rx_q.push_back(b1);      rx_q.push_back(b2);
        exp_cap.push_back({b1, b2, cnt});
    endtask

    task automatic pulse_motion();
        motion_int = 1'b1;
        repeat (2) @(negedge clk);
        motion_int = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (start_spi !== 1'b1 && n < 200);
        if (start_spi !== 1'b1) chk({name, " start_spi wait"}, 32'(start_spi), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((busy !== 1'b0 || exp_cap.size() != 0 || exp_tx.size() != 0) && n < 300);
        chk({name, " drained"}, 32'(exp_cap.size() + exp_tx.size()), 0);
    endtask

    initial begin
        int n;
        int s0;
        repeat (3) @(negedge clk);
        chk("rst sensor_data", 32'(sensor_data), 0);
        chk("rst event_count", 32'(event_count), 0);
        chk("rst data_valid", 32'(data_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst sensor_error", 32'(sensor_error), 0);
        chk("rst start_spi", 32'(start_spi), 0);
        chk("rst spi_tx_data", 32'(spi_tx_data), 0);

        // Poll: timer 20 hits 0 after edge 20, START at 21, start_spi after edge 22
        burst(8'h55, 8'h66, 2'd0);
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (start_spi !== 1'b1 && n < 100);
        chk("poll first start edge", n, 22);
        power_mode = 2'b11;
        wait_idle("poll burst");

        s0 = n_start;
        repeat (500) @(negedge clk);
        chk("poll-off start count", 32'(n_start - s0), 0);

        // Interrupt latency and burst
        burst(8'h12, 8'h34, 2'd1);
        motion_int = 1'b1;
        repeat (2) @(posedge clk);
        #1 motion_int = 1'b0;
        chk("irq busy after edge2", 32'(busy), 0);
        @(posedge clk); #1;
        chk("irq busy after edge3", 32'(busy), 1);
        chk("irq start after edge3", 32'(start_spi), 0);
        @(posedge clk); #1;
        chk("irq start after edge4", 32'(start_spi), 1);
        wait_idle("irq burst");

        // Pending: second edge coincides with final spi_done of burst 1
        burst(8'h11, 8'h22, 2'd1);
        burst(8'h33, 8'h44, 2'd1);
        @(negedge clk);
        pulse_motion();
        wait_start("pend b1 cmd");
        wait_start("pend b1 byte1");
        repeat (4) @(negedge clk);
        pulse_motion();
        n = 0;
        while (data_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("pend first capture seen", 32'(data_valid), 1);
        @(negedge clk);
        chk("pend DONE->START busy", 32'(busy), 1);
        chk("pend START start_spi", 32'(start_spi), 0);
        @(negedge clk);
        chk("pend restart start_spi", 32'(start_spi), 1);
        wait_idle("pending bursts");

        // Saturation: 4 edges while disabled, 5th edge triggers
        enable = 1'b0;
        repeat (4) begin
            pulse_motion();
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("disabled busy", 32'(busy), 0);
        enable = 1'b1;
        burst(8'hBE, 8'hEF, 2'd3);
        pulse_motion();
        wait_idle("saturation burst");

        // Timeout
        resp_en = 1'b0;
        exp_tx.push_back(8'hA0);
        pulse_motion();
        wait_start("timeout");
        repeat (8) @(negedge clk);
        chk("timeout ERROR busy", 32'(busy), 1);
        chk("timeout err before", 32'(sensor_error), 0);
        @(negedge clk);
        chk("timeout idle busy", 32'(busy), 0);
        chk("timeout sensor_error", 32'(sensor_error), 1);
        repeat (20) @(negedge clk);
        chk("sensor_error sticky", 32'(sensor_error), 1);
        chk("timeout tx drained", 32'(exp_tx.size()), 0);
        resp_en = 1'b1;
        burst(8'h0F, 8'hF0, 2'd2);
        pulse_motion();
        wait_idle("recovery burst");
        chk("error cleared by capture", 32'(sensor_error), 0);

        // Abort mid-burst; late spi_done must be ignored
        exp_tx.push_back(8'hA0);
        rx_q.push_back(8'hAA);
        pulse_motion();
        wait_start("abort");
        enable = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 0);
        chk("abort start_spi", 32'(start_spi), 0);
        repeat (10) @(negedge clk);
        chk("abort sensor_data held", 32'(sensor_data), 32'h0FF0);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-burst
        exp_tx.push_back(8'hA0);
        rx_q.push_back(8'hAA);
        pulse_motion();
        wait_start("reset");
        rst_n = 1'b0;
        #1;
        chk("async rst start_spi", 32'(start_spi), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst sensor_data", 32'(sensor_data), 0);
        chk("async rst event_count", 32'(event_count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        chk("final tx queue", 32'(exp_tx.size()), 0);
        chk("final cap queue", 32'(exp_cap.size()), 0);
        chk("final rx queue", 32'(rx_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
